ps2_mouse_packet_encoder: RTL and testbench

PS2_MOUSE_PACKET_ENCODER -- requirements
Module: ps2_mouse_packet_encoder

---
 rtl/ps2_mouse_packet_encoder_pkg.sv | 31 +++
 rtl/ps2_mouse_packet_encoder_axis_saturator.sv | 28 ++
 rtl/ps2_mouse_packet_encoder.sv | 136 +++++++++++++
 tb/tb_ps2_mouse_packet_encoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_packet_encoder_pkg.sv
// Shared definitions for the PS/2 mouse packet encoder: FSM encoding,
// status-byte bit positions and the saturating accumulator helper.
package ps2_mouse_packet_encoder_pkg;

    localparam int ACC_W = 12;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_SEND_STATUS = 3'd1;
    localparam logic [2:0] ST_SEND_X      = 3'd2;
    localparam logic [2:0] ST_SEND_Y      = 3'd3;
    localparam logic [2:0] ST_GAP         = 3'd4;

    localparam int ST_Y_OVF   = 7;
    localparam int ST_X_OVF   = 6;
    localparam int ST_Y_SIGN  = 5;
    localparam int ST_X_SIGN  = 4;
    localparam int ST_ALWAYS1 = 3;

    // One extra bit of headroom; a disagreement between the top two bits
    // means the sum left the 12-bit range and must be clamped.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [8:0]       delta);
        logic [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc} + {{(ACC_W-8){delta[8]}}, delta};
        if (sum[ACC_W] != sum[ACC_W-1])
            sat_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sat_add = sum[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/ps2_mouse_packet_encoder_axis_saturator.sv
// Maps a 12-bit signed accumulator onto the PS/2 9-bit movement range
// (8-bit field plus sign) with an overflow flag.
module ps2_axis_saturator
    import ps2_mouse_packet_encoder_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    output logic [7:0]       field,
    output logic             sign,
    output logic             ovf
);

    logic in_range;

    // In range [-256,255] exactly when bits above bit 8 all copy bit 8.
    assign in_range = (acc[ACC_W-1:8] == {(ACC_W-8){acc[8]}});

    always_comb begin
        field = acc[7:0];
        sign  = acc[8];
        ovf   = 1'b0;
        if (!in_range) begin
            ovf   = 1'b1;
            sign  = acc[ACC_W-1];
            field = acc[ACC_W-1] ? 8'h00 : 8'hFF;
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_encoder.sv
// Accumulates mouse motion and button changes and emits three-byte PS/2
// movement packets through a valid/ready byte interface.
module ps2_mouse_packet_encoder
    import ps2_mouse_packet_encoder_pkg::*;
#(
    parameter int GAP_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       report_en,
    input  logic [8:0] move_dx,
    input  logic [8:0] move_dy,
    input  logic [2:0] move_buttons,
    input  logic       move_valid,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       packet_sent,
    output logic       busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [2:0]       state;
    logic [ACC_W-1:0] acc_x, acc_y;
    logic [2:0]       btn_reg, last_btn;
    logic             btn_dirty;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       x_field, y_field, snap_x, snap_y, status;
    logic             x_sign, y_sign, x_ovf, y_ovf;
    logic             trigger, xfer, hold_clear;

    ps2_axis_saturator u_sat_x (.acc(acc_x), .field(x_field), .sign(x_sign), .ovf(x_ovf));
    ps2_axis_saturator u_sat_y (.acc(acc_y), .field(y_field), .sign(y_sign), .ovf(y_ovf));

    assign hold_clear = (state == ST_IDLE) && !report_en;
    assign trigger    = (state == ST_IDLE) && report_en &&
                        ((acc_x != '0) || (acc_y != '0) || btn_dirty);
    assign xfer       = tx_valid && tx_ready;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        status              = {5'b0, btn_reg};
        status[ST_ALWAYS1]  = 1'b1;
        status[ST_X_SIGN]   = x_sign;
        status[ST_Y_SIGN]   = y_sign;
        status[ST_X_OVF]    = x_ovf;
        status[ST_Y_OVF]    = y_ovf;
    end

    // On the snapshot edge a coincident move lands in the freshly cleared accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_x     <= '0;
            acc_y     <= '0;
            btn_reg   <= '0;
            last_btn  <= '0;
            btn_dirty <= 1'b0;
        end else begin
            if (move_valid)
                btn_reg <= move_buttons;
            if (hold_clear) begin
                acc_x     <= '0;
                acc_y     <= '0;
                btn_dirty <= 1'b0;
            end else if (trigger) begin
                acc_x     <= move_valid ? sat_add('0, move_dx) : '0;
                acc_y     <= move_valid ? sat_add('0, move_dy) : '0;
                last_btn  <= btn_reg;
                btn_dirty <= move_valid && (move_buttons != btn_reg);
            end else if (move_valid) begin
                acc_x <= sat_add(acc_x, move_dx);
                acc_y <= sat_add(acc_y, move_dy);
                if (move_buttons != last_btn)
                    btn_dirty <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tx_byte     <= 8'h00;
            tx_valid    <= 1'b0;
            packet_sent <= 1'b0;
            gap_cnt     <= '0;
            snap_x      <= 8'h00;
            snap_y      <= 8'h00;
        end else begin
            packet_sent <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state    <= ST_SEND_STATUS;
                        tx_byte  <= status;
                        tx_valid <= 1'b1;
                        snap_x   <= x_field;
                        snap_y   <= y_field;
                    end
                end
                ST_SEND_STATUS: begin
                    if (xfer) begin
                        state   <= ST_SEND_X;
                        tx_byte <= snap_x;
                    end
                end
                ST_SEND_X: begin
                    if (xfer) begin
                        state   <= ST_SEND_Y;
                        tx_byte <= snap_y;
                    end
                end
                ST_SEND_Y: begin
                    if (xfer) begin
                        tx_valid    <= 1'b0;
                        packet_sent <= 1'b1;
                        gap_cnt     <= GAP_LOAD;
                        state       <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_encoder.sv
// Directed self-checking bench for the PS/2 mouse packet encoder.
module tb_ps2_mouse_packet_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       report_en;
    logic [8:0] move_dx, move_dy;
    logic [2:0] move_buttons;
    logic       move_valid;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       packet_sent;
    logic       busy;

    int checks = 0;
    int errors = 0;

    ps2_mouse_packet_encoder #(.GAP_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .report_en    (report_en),
        .move_dx      (move_dx),
        .move_dy      (move_dy),
        .move_buttons (move_buttons),
        .move_valid   (move_valid),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .packet_sent  (packet_sent),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input int dx, input int dy, input logic [2:0] btn);
        move_dx      = 9'(dx);
        move_dy      = 9'(dy);
        move_buttons = btn;
        move_valid   = 1'b1;
        tick();
        move_valid   = 1'b0;
    endtask

    task automatic get_byte(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 50 && !tx_valid; i++) tick();
        check({tag, "_valid"}, {7'b0, tx_valid}, 8'h01);
        check(tag, tx_byte, exp);
        tick();
    endtask

    task automatic get_packet(input string tag, input logic [7:0] s,
                              input logic [7:0] x, input logic [7:0] y);
        get_byte({tag, "_status"}, s);
        get_byte({tag, "_x"}, x);
        get_byte({tag, "_y"}, y);
        check({tag, "_sent"}, {7'b0, packet_sent}, 8'h01);
        tick();
        check({tag, "_sent_pulse"}, {7'b0, packet_sent}, 8'h00);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy; i++) tick();
        check(tag, {7'b0, busy}, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; report_en = 1'b0; move_dx = '0; move_dy = '0;
        move_buttons = '0; move_valid = 1'b0; tx_ready = 1'b1;
        tick(); tick();
        check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_packet_sent", {7'b0, packet_sent}, 8'h00);
        rst_n = 1'b1;
        tick();
        report_en = 1'b1;
        tick();

        // Basic packet and trigger latency
        move(5, -3, 3'b001);
        check("lat_before", {7'b0, tx_valid}, 8'h00);
        tick();
        check("lat_after", {7'b0, tx_valid}, 8'h01);
        get_packet("basic", 8'h29, 8'h05, 8'hFD);
        wait_idle("basic_idle");

        // Stall during SEND_X while +200 x4 accumulates with buttons released
        tx_ready = 1'b0;
        move(1, 0, 3'b001);
        tick();
        check("stall_status", tx_byte, 8'h09);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            move_valid   = (i < 4);
            move_dx      = 9'd200;
            move_dy      = 9'd0;
            move_buttons = 3'b000;
            check("stall_x_byte", tx_byte, 8'h01);
            check("stall_x_valid", {7'b0, tx_valid}, 8'h01);
            tick();
        end
        move_valid = 1'b0;
        tx_ready = 1'b1;
        get_byte("stall_x", 8'h01);
        get_byte("stall_y", 8'h00);
        check("stall_sent", {7'b0, packet_sent}, 8'h01);
        get_packet("xovf", 8'h48, 8'hFF, 8'h00);
        wait_idle("xovf_idle");

        // Move coincident with the snapshot edge
        move(3, 0, 3'b000);
        move(7, 0, 3'b000);
        get_packet("snap1", 8'h08, 8'h03, 8'h00);
        get_packet("snap2", 8'h08, 8'h07, 8'h00);
        wait_idle("snap_idle");

        // Button-only change, then an unchanged repeat
        move(0, 0, 3'b010);
        get_packet("btn", 8'h0A, 8'h00, 8'h00);
        wait_idle("btn_idle");
        move(0, 0, 3'b010);
        for (int i = 0; i < 10; i++) tick();
        check("btn_repeat_busy", {7'b0, busy}, 8'h00);
        check("btn_repeat_valid", {7'b0, tx_valid}, 8'h00);

        // Motion while reporting is disabled is discarded
        report_en = 1'b0;
        move(9, 9, 3'b010);
        tick();
        report_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("disabled_busy", {7'b0, busy}, 8'h00);

        // Range boundaries: +255, -256 in range; -257 overflows
        tx_ready = 1'b0;
        move(255, -256, 3'b010);
        move(0, -256, 3'b010);
        move(0, -1, 3'b010);
        tx_ready = 1'b1;
        get_packet("edge", 8'h2A, 8'hFF, 8'h00);
        get_packet("yovf", 8'hAA, 8'h00, 8'h00);
        wait_idle("yovf_idle");

        // Reset while SEND_Y is pending
        move(1, 1, 3'b010);
        get_byte("rst_pkt_status", 8'h0A);
        get_byte("rst_pkt_x", 8'h01);
        tx_ready = 1'b0;
        check("rst_pkt_y_pending", tx_byte, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", {7'b0, tx_valid}, 8'h00);
        check("midrst_busy", {7'b0, busy}, 8'h00);
        tick(); tick();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("postrst_sent", {7'b0, packet_sent}, 8'h00);
            tick();
        end
        check("postrst_valid", {7'b0, tx_valid}, 8'h00);
        move(2, 0, 3'b000);
        get_packet("fresh", 8'h08, 8'h02, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
